// File: rtl/pipe_pkg.sv
// Shared stage-register definitions: state encoding and occupancy constants
// used by every pipeline stage built on pipe_stage_reg.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  function automatic logic [1:0] occ_of(input stage_state_e st);
    case (st)
      ST_ONE:  return OCC_ONE;
      ST_TWO:  return OCC_TWO;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One stage slot (valid + ctrl + data) with load enable and synchronous clear; 1-cycle load.
// No handshake of its own: the owning stage decides when to load, so backpressure lives there.
module pipe_entry_reg #(
  parameter int unsigned       CTRL_W      = 16,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr,
  input  logic              load_en,
  input  logic              d_vld,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_dat,
  output logic              q_vld,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_dat
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q_vld  <= 1'b0;
      q_ctrl <= BUBBLE_CTRL;
      q_dat  <= '0;
    end else if (clr) begin
      q_vld  <= 1'b0;
      q_ctrl <= BUBBLE_CTRL;
      q_dat  <= '0;
    end else if (load_en) begin
      q_vld  <= d_vld;
      q_ctrl <= d_vld ? d_ctrl : BUBBLE_CTRL;
      // An emptied slot keeps its last payload; only ctrl turns into a bubble.
      if (d_vld) q_dat <= d_dat;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register, 1-cycle latency, full throughput; SKID=1 adds a skid slot so
// in_ready_o is registered, SKID=0 holds one entry with in_ready_o = !out_valid_o || out_ready_i.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       CTRL_W      = 16,
  parameter int unsigned       SKID        = 1,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_enable_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  stage_state_e      state_q, state_d;
  logic              in_rdy_q;
  logic              push, pop;
  logic              main_load, main_d_vld, main_from_skid;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_dat;
  logic              main_vld;
  logic              skid_load, skid_d_vld;
  logic              skid_vld;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_dat;

  assign push = in_valid_i & in_ready_o;
  assign pop  = main_vld & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_EMPTY;
      in_rdy_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_rdy_q <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_d_vld     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_d_vld     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d    = ST_ONE;
          main_load  = 1'b1;
          main_d_vld = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_load  = 1'b1;
          main_d_vld = 1'b1;
        end else if (push) begin
          // Only reachable with SKID=1: single-entry mode never accepts without a pop.
          state_d    = ST_TWO;
          skid_load  = 1'b1;
          skid_d_vld = 1'b1;
        end else if (pop) begin
          state_d    = ST_EMPTY;
          main_load  = 1'b1;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d        = ST_ONE;
          main_load      = 1'b1;
          main_d_vld     = skid_vld;
          main_from_skid = 1'b1;
          skid_load      = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_enable_i) state_d = ST_EMPTY;
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl_i;
  assign main_d_dat  = main_from_skid ? skid_dat  : in_data_i;

  pipe_entry_reg #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (flush_enable_i),
    .load_en (main_load),
    .d_vld   (main_d_vld),
    .d_ctrl  (main_d_ctrl),
    .d_dat   (main_d_dat),
    .q_vld   (main_vld),
    .q_ctrl  (out_ctrl_o),
    .q_dat   (out_data_o)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .BUBBLE_CTRL (BUBBLE_CTRL)
      ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (flush_enable_i),
        .load_en (skid_load),
        .d_vld   (skid_d_vld),
        .d_ctrl  (in_ctrl_i),
        .d_dat   (in_data_i),
        .q_vld   (skid_vld),
        .q_ctrl  (skid_ctrl),
        .q_dat   (skid_dat)
      );
      assign in_ready_o = in_rdy_q;
    end else begin : g_single
      assign skid_vld   = 1'b0;
      assign skid_ctrl  = BUBBLE_CTRL;
      assign skid_dat   = '0;
      assign in_ready_o = !main_vld || out_ready_i;
    end
  endgenerate

  assign out_valid_o = main_vld;
  assign occupancy_o = occ_of(state_q);

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the datapath payload (register data, immediates, PC).
REQ-002 The block SHALL have parameter CTRL_W, default 16, meaning the width of the control payload (Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite, jump_enable, ...).
REQ-003 The block SHALL have parameter SKID, default 1, meaning 1 selects a two-entry skid stage with registered in_ready_o and 0 selects a single-entry stage.
REQ-004 The block SHALL have parameter BUBBLE_CTRL, default all-zero (CTRL_W bits), meaning the control value presented whenever the stage holds no valid entry.
REQ-005 The block SHALL have port clk_i, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit, meaning reset; reset is asynchronous and active-low.
REQ-007 The block SHALL have port flush_enable_i, input, 1 bit, meaning a synchronous kill of all held entries.
REQ-008 The block SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1), in_ctrl_i (input, CTRL_W) and in_data_i (input, DATA_W), forming the upstream handshake.
REQ-009 The block SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_ctrl_o (output, CTRL_W) and out_data_o (output, DATA_W), forming the downstream handshake.
REQ-010 The block SHALL have port occupancy_o, output, 2 bits, meaning the number of valid entries held (0..2).

Function
REQ-011 An input transfer SHALL occur on a rising edge where in_valid_i and in_ready_o are both 1; an output transfer SHALL occur where out_valid_o and out_ready_i are both 1.
REQ-012 Entries SHALL leave in acceptance order; latency from input transfer to out_valid_o=1 SHALL be exactly 1 cycle when the stage was empty.
REQ-013 Sustained throughput SHALL be one transfer per cycle when out_ready_i is held at 1, for both SKID values.
REQ-014 With SKID=1 the block SHALL implement states EMPTY, ONE (main full) and TWO (main and skid full); out_* SHALL always be driven from the main entry.
REQ-015 The state transitions SHALL be: EMPTY+push->ONE; ONE+push+pop->ONE (main loads input); ONE+push only->TWO (skid loads input); ONE+pop only->EMPTY; TWO+pop->ONE (main loads skid); all other cases hold.
REQ-016 With SKID=1, in_ready_o SHALL be a registered signal equal to 1 exactly when the state is not TWO.
REQ-017 With SKID=0, in_ready_o SHALL equal (!out_valid_o || out_ready_i), and the block SHALL hold at most one entry.
REQ-018 While out_valid_o=1 and out_ready_i=0, out_ctrl_o and out_data_o SHALL remain stable.
REQ-019 When the main entry becomes empty, out_ctrl_o SHALL become BUBBLE_CTRL on the same edge; out_data_o SHALL hold its last value.
REQ-020 flush_enable_i=1 SHALL have the highest priority: on that edge, state SHALL go to EMPTY and out_ctrl_o SHALL go to BUBBLE_CTRL.
REQ-021 On a flush edge, out_data_o SHALL go to zero, any input offered on the same edge SHALL be discarded, and in_ready_o SHALL be 1 on the following cycle.
REQ-022 occupancy_o SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO respectively, and SHALL never exceed 1 when SKID=0.

Reset
REQ-023 While rst_i=0, the state SHALL be EMPTY, out_valid_o=0, out_ctrl_o=BUBBLE_CTRL, out_data_o=0, occupancy_o=0, all skid contents SHALL be zero, and in_ready_o=1.
REQ-024 Reset assertion mid-transfer SHALL discard all entries asynchronously, and no output transfer SHALL be reported in the first cycle after deassertion.

Structure
REQ-025 The state encoding (EMPTY/ONE/TWO) and the occupancy constants SHALL reside in the shared package pipe_pkg.
REQ-026 The per-entry storage (valid + ctrl + data with load enable and clear) SHALL be the sub-module pipe_entry_reg, instantiated once for main and once for skid when SKID=1.
REQ-027 id_exe-style stages SHALL be built by concatenating their fields into ctrl/data vectors at the instantiation site.

Verification
REQ-028 The bench SHALL drive 8 back-to-back pushes (data 0x1..0x8) with out_ready_i=1 and check that out_data_o delivers 0x1..0x8 on consecutive cycles, starting 1 cycle after the first push.
REQ-029 The bench SHALL use SKID=1, push 0xA then 0xB with out_ready_i=0, and check occupancy_o=2 and in_ready_o=0; after raising out_ready_i it SHALL check outputs 0xA then 0xB and occupancy_o returning to 0.
REQ-030 The bench SHALL flush in state TWO while pushing 0xC and check occupancy_o=0, out_valid_o=0, out_ctrl_o=BUBBLE_CTRL, out_data_o=0 next cycle, and that 0xC never appears.
REQ-031 The bench SHALL use SKID=0, hold a valid entry with out_ready_i=0, and check in_ready_o=0; with out_ready_i=1 and in_valid_i=1 it SHALL check that entries replace each other every cycle.
REQ-032 The bench SHALL assert rst_i=0 asynchronously mid-cycle while in state ONE and check that all outputs immediately take their REQ-023 values.
REQ-033 The bench SHALL apply random valid/ready stimulus (10k cycles, both SKID values) and check ordering, no loss/duplication, stability under backpressure, and occupancy_o against a reference queue.
